// File: rtl/tsn_axis_pkg.sv
// Shared definitions for the TSN AXI-Stream datapath: EtherTypes, traffic classes and beat payload.
package tsn_axis_pkg;

    localparam int unsigned AXIS_DATA_W = 256;
    localparam int unsigned AXIS_KEEP_W = AXIS_DATA_W / 8;

    localparam logic [15:0] ETH_TYPE_CRITICAL = 16'h66ab;
    localparam logic [15:0] ETH_TYPE_PTP      = 16'h88f7;
    localparam logic [15:0] ETH_TYPE_VLAN     = 16'h8100;

    localparam logic [1:0] FRAME_TYPE_CRITICAL = 2'd0;
    localparam logic [1:0] FRAME_TYPE_PTP      = 2'd1;
    localparam logic [1:0] FRAME_TYPE_IT       = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_PASS  = 2'd2,
        ST_TAIL  = 2'd3
    } vlan_ins_state_t;

    typedef struct packed {
        logic [AXIS_DATA_W-1:0] tdata;
        logic [AXIS_KEEP_W-1:0] tkeep;
        logic                   tlast;
    } axis_beat_t;

    // EtherType sits in bytes 12 (MSB) and 13 (LSB) of the first beat.
    function automatic logic [15:0] eth_type_of(input logic [AXIS_DATA_W-1:0] data);
        return {data[103:96], data[111:104]};
    endfunction

endpackage

// File: rtl/eth_type_classify.sv
// Maps an EtherType to its traffic class and the PCP that class is tagged with.
module eth_type_classify
    import tsn_axis_pkg::*;
#(
    parameter logic [2:0] PCP_CRITICAL = 3'd7,
    parameter logic [2:0] PCP_PTP      = 3'd6,
    parameter logic [2:0] PCP_IT       = 3'd0
) (
    input  logic [15:0] eth_type,
    output logic [1:0]  frame_type_c,
    output logic [2:0]  pcp_c
);

    always_comb begin
        frame_type_c = FRAME_TYPE_IT;
        pcp_c        = PCP_IT;
        if (eth_type == ETH_TYPE_CRITICAL) begin
            frame_type_c = FRAME_TYPE_CRITICAL;
            pcp_c        = PCP_CRITICAL;
        end else if (eth_type == ETH_TYPE_PTP) begin
            frame_type_c = FRAME_TYPE_PTP;
            pcp_c        = PCP_PTP;
        end
    end

endmodule

// File: rtl/axis_vlan_inserter.sv
// Egress 802.1Q tagger: inserts a class-dependent VLAN tag after the MAC addresses and
// realigns the rest of the frame by 4 bytes, with a single registered output stage.
module axis_vlan_inserter
    import tsn_axis_pkg::*;
#(
    parameter logic [2:0] PCP_CRITICAL = 3'd7,
    parameter logic [2:0] PCP_PTP      = 3'd6,
    parameter logic [2:0] PCP_IT       = 3'd0
) (
    input  logic         axis_aclk,
    input  logic         rst,
    input  logic         cfg_enable,
    input  logic [11:0]  cfg_vid,
    input  logic [255:0] s_axis_tdata,
    input  logic [31:0]  s_axis_tkeep,
    input  logic         s_axis_tvalid,
    input  logic         s_axis_tlast,
    output logic         s_axis_tready,
    output logic [255:0] m_axis_tdata,
    output logic [31:0]  m_axis_tkeep,
    output logic         m_axis_tvalid,
    output logic         m_axis_tlast,
    input  logic         m_axis_tready,
    output logic [1:0]   frame_type,
    output logic [31:0]  tagged_count
);

    vlan_ins_state_t state_q, state_d;
    axis_beat_t      beat_q, beat_d;
    logic            valid_q, valid_d;
    logic [31:0]     carry_q, carry_d;
    logic [3:0]      ckeep_q, ckeep_d;
    logic [1:0]      ftype_q, ftype_d;
    logic [31:0]     count_q, count_d;

    logic [15:0] eth_type_c;
    logic [1:0]  class_type_c;
    logic [2:0]  class_pcp_c;
    logic [15:0] tci_c;
    logic        tag_c;
    logic        out_free_c;
    logic        accept_c;
    logic        realign_c;

    assign eth_type_c = eth_type_of(s_axis_tdata);

    eth_type_classify #(
        .PCP_CRITICAL (PCP_CRITICAL),
        .PCP_PTP      (PCP_PTP),
        .PCP_IT       (PCP_IT)
    ) u_classify (
        .eth_type     (eth_type_c),
        .frame_type_c (class_type_c),
        .pcp_c        (class_pcp_c)
    );

    assign tci_c      = {class_pcp_c, 1'b0, cfg_vid};
    assign tag_c      = cfg_enable && s_axis_tkeep[13] && (eth_type_c != ETH_TYPE_VLAN);
    assign out_free_c = !valid_q || m_axis_tready;

    assign s_axis_tready = out_free_c && (state_q != ST_TAIL);
    assign accept_c      = s_axis_tvalid && s_axis_tready;

    // Next-state and next-output computation for every register.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        valid_d   = valid_q && !m_axis_tready;
        carry_d   = carry_q;
        ckeep_d   = ckeep_q;
        ftype_d   = ftype_q;
        count_d   = count_q;
        realign_c = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    valid_d = 1'b1;
                    ftype_d = class_type_c;
                    if (tag_c) begin
                        beat_d.tdata = {s_axis_tdata[223:96], tci_c[7:0], tci_c[15:8],
                                        8'h00, 8'h81, s_axis_tdata[95:0]};
                        beat_d.tkeep = {s_axis_tkeep[27:12], 4'hF, s_axis_tkeep[11:0]};
                        count_d      = count_q + 32'd1;
                        realign_c    = 1'b1;
                    end else begin
                        beat_d.tdata = s_axis_tdata;
                        beat_d.tkeep = s_axis_tkeep;
                        beat_d.tlast = s_axis_tlast;
                        state_d      = s_axis_tlast ? ST_IDLE : ST_PASS;
                    end
                end
            end
            ST_SHIFT: begin
                if (accept_c) begin
                    valid_d      = 1'b1;
                    beat_d.tdata = {s_axis_tdata[223:0], carry_q};
                    beat_d.tkeep = {s_axis_tkeep[27:0], ckeep_q};
                    realign_c    = 1'b1;
                end
            end
            ST_PASS: begin
                if (accept_c) begin
                    valid_d      = 1'b1;
                    beat_d.tdata = s_axis_tdata;
                    beat_d.tkeep = s_axis_tkeep;
                    beat_d.tlast = s_axis_tlast;
                    if (s_axis_tlast) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_TAIL: begin
                if (out_free_c) begin
                    valid_d      = 1'b1;
                    beat_d.tdata = {224'b0, carry_q};
                    beat_d.tkeep = {28'b0, ckeep_q};
                    beat_d.tlast = 1'b1;
                    state_d      = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Tagged beats push their top 4 bytes into the next beat; a tail beat is needed
        // only when those bytes are live on the last input beat.
        if (realign_c) begin
            carry_d = s_axis_tdata[255:224];
            ckeep_d = s_axis_tkeep[31:28];
            if (!s_axis_tlast) begin
                beat_d.tlast = 1'b0;
                state_d      = ST_SHIFT;
            end else if (s_axis_tkeep[28]) begin
                beat_d.tlast = 1'b0;
                state_d      = ST_TAIL;
            end else begin
                beat_d.tlast = 1'b1;
                state_d      = ST_IDLE;
            end
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            valid_q <= 1'b0;
            carry_q <= '0;
            ckeep_q <= '0;
            ftype_q <= FRAME_TYPE_IT;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
            carry_q <= carry_d;
            ckeep_q <= ckeep_d;
            ftype_q <= ftype_d;
            count_q <= count_d;
        end
    end

    assign m_axis_tdata  = beat_q.tdata;
    assign m_axis_tkeep  = beat_q.tkeep;
    assign m_axis_tlast  = beat_q.tlast;
    assign m_axis_tvalid = valid_q;
    assign frame_type    = ftype_q;
    assign tagged_count  = count_q;

endmodule

// File: tb/tb_axis_vlan_inserter.sv
// Scoreboard bench for axis_vlan_inserter: a byte-stream reference model predicts every
// output beat, which is popped and compared as the DUT hands it over.
module tb_axis_vlan_inserter;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
        logic         en;
        logic [11:0]  vid;
    } in_beat_t;

    typedef struct packed {
        logic [255:0] data;
        logic [31:0]  keep;
        logic         last;
        logic [1:0]   ftype;
    } out_beat_t;

    logic         axis_aclk     = 1'b0;
    logic         rst           = 1'b1;
    logic         cfg_enable    = 1'b1;
    logic [11:0]  cfg_vid       = '0;
    logic [255:0] s_axis_tdata  = '0;
    logic [31:0]  s_axis_tkeep  = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tlast  = 1'b0;
    logic         s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tkeep;
    logic         m_axis_tvalid;
    logic         m_axis_tlast;
    logic         m_axis_tready = 1'b1;
    logic [1:0]   frame_type;
    logic [31:0]  tagged_count;

    axis_vlan_inserter dut (
        .axis_aclk     (axis_aclk),
        .rst           (rst),
        .cfg_enable    (cfg_enable),
        .cfg_vid       (cfg_vid),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .frame_type    (frame_type),
        .tagged_count  (tagged_count)
    );

    always #5 axis_aclk = ~axis_aclk;

    in_beat_t    in_q[$];
    out_beat_t   exp_q[$];
    out_beat_t   out_log[$];
    int          vectors     = 0;
    int          miscompares = 0;
    int          stalls      = 0;
    logic [31:0] exp_tagged  = '0;

    // Builds one frame of random payload, queues its input beats and the predicted output.
    task automatic push_frame(input int len, input logic [15:0] et, input logic en,
                              input logic [11:0] vid);
        logic [7:0] fb[$];
        logic [7:0] ob[$];
        logic [15:0] et_obs;
        logic [1:0]  ft;
        logic [2:0]  pcp;
        logic        tag;
        int          nb;
        in_beat_t    ib;
        out_beat_t   eb;
        for (int i = 0; i < len; i++) fb.push_back(8'($urandom));
        if (len > 12) fb[12] = et[15:8];
        if (len > 13) fb[13] = et[7:0];
        et_obs = {(len > 12) ? fb[12] : 8'h00, (len > 13) ? fb[13] : 8'h00};
        ft  = (et_obs == 16'h66ab) ? 2'd0 : (et_obs == 16'h88f7) ? 2'd1 : 2'd2;
        pcp = (ft == 2'd0) ? 3'd7 : (ft == 2'd1) ? 3'd6 : 3'd0;
        tag = en && (len >= 14) && (et_obs != 16'h8100);

        nb = (len + 31) / 32;
        for (int b = 0; b < nb; b++) begin
            ib = '0;
            for (int j = 0; j < 32; j++) begin
                if (32 * b + j < len) begin
                    ib.data[8*j +: 8] = fb[32*b+j];
                    ib.keep[j] = 1'b1;
                end
            end
            ib.last = (b == nb - 1);
            ib.en   = (b == 0) ? en : 1'($urandom);
            ib.vid  = (b == 0) ? vid : 12'($urandom);
            in_q.push_back(ib);
        end

        if (tag) begin
            for (int i = 0; i < 12; i++) ob.push_back(fb[i]);
            ob.push_back(8'h81);
            ob.push_back(8'h00);
            ob.push_back({pcp, 1'b0, vid[11:8]});
            ob.push_back(vid[7:0]);
            for (int i = 12; i < len; i++) ob.push_back(fb[i]);
            exp_tagged = exp_tagged + 32'd1;
        end else begin
            ob = fb;
        end

        nb = (ob.size() + 31) / 32;
        for (int b = 0; b < nb; b++) begin
            eb = '0;
            for (int j = 0; j < 32; j++) begin
                if (32 * b + j < ob.size()) begin
                    eb.data[8*j +: 8] = ob[32*b+j];
                    eb.keep[j] = 1'b1;
                end
            end
            eb.last  = (b == nb - 1);
            eb.ftype = ft;
            exp_q.push_back(eb);
        end
    endtask

    // Drives queued input beats, optionally throttles m_axis_tready, and scores every output beat.
    task automatic run(input int budget, input bit bp, input int stop_after);
        int        cyc = 0;
        int        taken = 0;
        bit        fire;
        bit        stalled = 1'b0;
        out_beat_t held;
        out_beat_t got;
        out_beat_t e;
        held = '0;
        out_log = {};
        stalls = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && cyc < budget &&
               !(stop_after != 0 && taken >= stop_after)) begin
            @(negedge axis_aclk);
            if (in_q.size() != 0) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = in_q[0].data;
                s_axis_tkeep  = in_q[0].keep;
                s_axis_tlast  = in_q[0].last;
                cfg_enable    = in_q[0].en;
                cfg_vid       = in_q[0].vid;
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = '0;
                s_axis_tkeep  = '0;
                s_axis_tlast  = 1'b0;
            end
            m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            got.data  = m_axis_tdata;
            got.keep  = m_axis_tkeep;
            got.last  = m_axis_tlast;
            got.ftype = frame_type;
            if (stalled) begin
                vectors++;
                if ({got, m_axis_tvalid} !== {held, 1'b1}) begin
                    miscompares++;
                    $display("FAIL hold_stable: got valid=%b keep=%h last=%b, expected held keep=%h last=%b",
                             m_axis_tvalid, got.keep, got.last, held.keep, held.last);
                end
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            held    = got;
            if (m_axis_tvalid && m_axis_tready) begin
                vectors++;
                out_log.push_back(got);
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_beat: got data=%h keep=%h last=%b, expected no beat",
                             got.data, got.keep, got.last);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        miscompares++;
                        $display("FAIL scoreboard: got data=%h keep=%h last=%b ft=%0d, expected data=%h keep=%h last=%b ft=%0d",
                                 got.data, got.keep, got.last, got.ftype,
                                 e.data, e.keep, e.last, e.ftype);
                    end
                end
            end
            if (s_axis_tvalid && !s_axis_tready) stalls++;
            fire = s_axis_tvalid && s_axis_tready;
            @(posedge axis_aclk);
            if (fire) begin
                void'(in_q.pop_front());
                taken++;
            end
            cyc++;
        end
        #1;
        s_axis_tvalid = 1'b0;
        if (stop_after == 0) begin
            vectors++;
            if (in_q.size() != 0 || exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL drain_timeout: got %0d inputs and %0d outputs pending, expected 0 and 0",
                         in_q.size(), exp_q.size());
                in_q  = {};
                exp_q = {};
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge axis_aclk);
        @(negedge axis_aclk);
        vectors += 6;
        if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL rst_tvalid: got %b, expected 0", m_axis_tvalid); end
        if (m_axis_tlast !== 1'b0) begin miscompares++; $display("FAIL rst_tlast: got %b, expected 0", m_axis_tlast); end
        if (m_axis_tkeep !== 32'h0) begin miscompares++; $display("FAIL rst_tkeep: got %h, expected 0", m_axis_tkeep); end
        if (m_axis_tdata !== 256'h0) begin miscompares++; $display("FAIL rst_tdata: got %h, expected 0", m_axis_tdata); end
        if (frame_type !== 2'd2) begin miscompares++; $display("FAIL rst_frame_type: got %0d, expected 2", frame_type); end
        if (tagged_count !== 32'd0) begin miscompares++; $display("FAIL rst_count: got %0d, expected 0", tagged_count); end
        rst = 1'b0;
        #1;
        vectors++;
        if (s_axis_tready !== 1'b1) begin miscompares++; $display("FAIL rst_tready: got %b, expected 1", s_axis_tready); end
    endtask

    task automatic test_critical_64();
        push_frame(64, 16'h66ab, 1'b1, 12'h005);
        run(200, 1'b0, 0);
        vectors++;
        if (out_log.size() != 3) begin
            miscompares++;
            $display("FAIL crit_beats: got %0d, expected 3", out_log.size());
        end else begin
            vectors += 3;
            if (out_log[0].data[127:96] !== 32'h05e00081) begin
                miscompares++; $display("FAIL crit_tag_bytes: got %h, expected 05e00081", out_log[0].data[127:96]);
            end
            if ({out_log[2].keep, out_log[2].last} !== {32'h0000000f, 1'b1}) begin
                miscompares++; $display("FAIL crit_tail: got keep=%h last=%b, expected keep=0000000f last=1",
                                        out_log[2].keep, out_log[2].last);
            end
            if (out_log[0].ftype !== 2'd0) begin
                miscompares++; $display("FAIL crit_ftype: got %0d, expected 0", out_log[0].ftype);
            end
        end
        vectors++;
        if (tagged_count !== exp_tagged) begin
            miscompares++; $display("FAIL crit_count: got %0d, expected %0d", tagged_count, exp_tagged);
        end
    endtask

    task automatic test_ptp_60();
        push_frame(60, 16'h88f7, 1'b1, 12'h123);
        run(200, 1'b0, 0);
        vectors++;
        if (out_log.size() != 2) begin
            miscompares++;
            $display("FAIL ptp_beats: got %0d, expected 2", out_log.size());
        end else begin
            vectors += 3;
            if ({out_log[1].keep, out_log[1].last} !== {32'hffffffff, 1'b1}) begin
                miscompares++; $display("FAIL ptp_last: got keep=%h last=%b, expected keep=ffffffff last=1",
                                        out_log[1].keep, out_log[1].last);
            end
            if (out_log[0].data[127:112] !== 16'h23c1) begin
                miscompares++; $display("FAIL ptp_tci: got %h, expected 23c1", out_log[0].data[127:112]);
            end
            if (out_log[1].ftype !== 2'd1) begin
                miscompares++; $display("FAIL ptp_ftype: got %0d, expected 1", out_log[1].ftype);
            end
        end
    endtask

    task automatic test_passthrough();
        in_beat_t    snap[$];
        logic [31:0] cnt0;
        cnt0 = tagged_count;
        push_frame(70, 16'h8100, 1'b1, 12'h0aa);
        push_frame(50, 16'h66ab, 1'b0, 12'h0bb);
        snap = in_q;
        run(200, 1'b0, 0);
        vectors++;
        if (out_log.size() != snap.size()) begin
            miscompares++;
            $display("FAIL pass_beats: got %0d, expected %0d", out_log.size(), snap.size());
        end else begin
            for (int i = 0; i < snap.size(); i++) begin
                vectors++;
                if ({out_log[i].data, out_log[i].keep, out_log[i].last} !==
                    {snap[i].data, snap[i].keep, snap[i].last}) begin
                    miscompares++;
                    $display("FAIL pass_identical[%0d]: got keep=%h last=%b, expected keep=%h last=%b",
                             i, out_log[i].keep, out_log[i].last, snap[i].keep, snap[i].last);
                end
            end
        end
        vectors++;
        if (tagged_count !== cnt0) begin
            miscompares++; $display("FAIL pass_count: got %0d, expected %0d", tagged_count, cnt0);
        end
    endtask

    task automatic test_runt_then_it();
        push_frame(12, 16'h0000, 1'b1, 12'h0ab);
        push_frame(100, 16'h0800, 1'b1, 12'h0ab);
        run(200, 1'b0, 0);
        vectors++;
        if (out_log.size() != 5) begin
            miscompares++;
            $display("FAIL runt_beats: got %0d, expected 5", out_log.size());
        end else begin
            vectors += 3;
            if ({out_log[0].keep, out_log[0].last} !== {32'h00000fff, 1'b1}) begin
                miscompares++; $display("FAIL runt_keep: got keep=%h last=%b, expected keep=00000fff last=1",
                                        out_log[0].keep, out_log[0].last);
            end
            if (out_log[1].data[127:96] !== 32'hab000081) begin
                miscompares++; $display("FAIL it_tag_bytes: got %h, expected ab000081", out_log[1].data[127:96]);
            end
            if (out_log[1].ftype !== 2'd2) begin
                miscompares++; $display("FAIL it_ftype: got %0d, expected 2", out_log[1].ftype);
            end
        end
        vectors++;
        if (tagged_count !== exp_tagged) begin
            miscompares++; $display("FAIL it_count: got %0d, expected %0d", tagged_count, exp_tagged);
        end
    endtask

    task automatic test_back_to_back();
        push_frame(60, 16'h0800, 1'b1, 12'h111);
        push_frame(60, 16'h88f7, 1'b1, 12'h222);
        run(200, 1'b0, 0);
        vectors++;
        if (stalls != 0) begin
            miscompares++; $display("FAIL b2b_no_tail_stalls: got %0d, expected 0", stalls);
        end
        push_frame(64, 16'h66ab, 1'b1, 12'h333);
        push_frame(60, 16'h0800, 1'b1, 12'h444);
        run(200, 1'b0, 0);
        vectors++;
        if (stalls != 1) begin
            miscompares++; $display("FAIL b2b_tail_stalls: got %0d, expected 1", stalls);
        end
    endtask

    task automatic test_random_backpressure();
        logic [15:0] ets[5];
        ets[0] = 16'h66ab; ets[1] = 16'h88f7; ets[2] = 16'h0800; ets[3] = 16'h8100; ets[4] = 16'h86dd;
        for (int f = 0; f < 100; f++) begin
            push_frame(($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 13)) : int'($urandom_range(14, 190)),
                       ets[$urandom_range(0, 4)], 1'($urandom_range(0, 7) != 0), 12'($urandom));
        end
        run(30000, 1'b1, 0);
        vectors++;
        if (tagged_count !== exp_tagged) begin
            miscompares++; $display("FAIL rand_count: got %0d, expected %0d", tagged_count, exp_tagged);
        end
    endtask

    task automatic test_reset_mid_shift();
        push_frame(128, 16'h66ab, 1'b1, 12'h321);
        run(100, 1'b0, 2);
        @(negedge axis_aclk);
        rst = 1'b1;
        m_axis_tready = 1'b1;
        @(negedge axis_aclk);
        vectors += 3;
        if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL mid_rst_tvalid: got %b, expected 0", m_axis_tvalid); end
        if (m_axis_tkeep !== 32'h0) begin miscompares++; $display("FAIL mid_rst_tkeep: got %h, expected 0", m_axis_tkeep); end
        if (tagged_count !== 32'd0) begin miscompares++; $display("FAIL mid_rst_count: got %0d, expected 0", tagged_count); end
        rst = 1'b0;
        #1;
        vectors++;
        if (s_axis_tready !== 1'b1) begin miscompares++; $display("FAIL mid_rst_tready: got %b, expected 1", s_axis_tready); end
        in_q       = {};
        exp_q      = {};
        exp_tagged = '0;
        push_frame(40, 16'h88f7, 1'b1, 12'h456);
        run(200, 1'b0, 0);
        vectors++;
        if (tagged_count !== exp_tagged) begin
            miscompares++; $display("FAIL mid_rst_fresh_count: got %0d, expected %0d", tagged_count, exp_tagged);
        end
    endtask

    initial begin
        test_reset();
        test_critical_64();
        test_ptp_60();
        test_passthrough();
        test_runt_then_it();
        test_back_to_back();
        test_random_backpressure();
        test_reset_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected bench to finish");
        $fatal(1);
    end

endmodule
